dec_92_10: RTL and testbench
============================

Name: dec_92_10

Overview:
- Sequential dense-layer decoder, the inverse stage of the 10->92 encoder: maps a 92-element latent vector back to 10 outputs.
- Computes y[o] = sat16((sum_i w[o][i]*x[i]) >>> FRAC + b[o]) in Q4.11, using one time-multiplexed signed MAC.
- Start/done handshake. Sits downstream of the encoder (and any latent processing) and feeds reconstruction checking.

Parameters:
- BITSIZE, 16, width of every x/w/b/y element (signed two's complement)
- IN_SIZE, 92, number of input (latent) elements
- OUT_SIZE, 10, number of output elements
- FRAC, 11, fractional bits of the fixed-point format (Q4.11)
- ACC_W, 40, accumulator width; must be >= 2*BITSIZE + ceil(log2(IN_SIZE))

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request a decode; sampled only in IDLE or DONE
- x  input  BITSIZE*IN_SIZE  element i at x[i*BITSIZE +: BITSIZE]
- w  input  BITSIZE*OUT_SIZE*IN_SIZE  w[o][i] at w[(o*IN_SIZE+i)*BITSIZE +: BITSIZE]
- b  input  BITSIZE*OUT_SIZE  b[o] at b[o*BITSIZE +: BITSIZE]
- y  output  BITSIZE*OUT_SIZE  y[o] at y[o*BITSIZE +: BITSIZE], registered
- busy  output  1  high in MAC and FIN states
- done  output  1  high in DONE state

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; y, accumulator, counters o and i all 0; busy=0; done=0. Reset asserted mid-decode aborts the decode immediately; y returns to 0.
- States:
  - IDLE: start=1 -> MAC; clear acc, set o=0, i=0.
  - MAC: each cycle acc += sext(w[o][i]*x[i]) (full 2*BITSIZE signed product); i++. After i=IN_SIZE-1 -> FIN.
  - FIN: r = (acc >>> FRAC) + sext(b[o]). Arithmetic shift, i.e. truncation toward -inf, no rounding. r is saturated to [-32768, 32767] and written to y[o]; acc cleared, i=0. If o=OUT_SIZE-1 -> DONE, else o++ and -> MAC.
  - DONE: done=1, held. start=1 -> MAC with the same clearing as in IDLE; done drops on that edge.
- Latency: the edge that samples start is edge 0. done rises after edge OUT_SIZE*(IN_SIZE+1), which is 930 with the defaults.
- start is ignored while busy. x, w and b must stay stable from edge 0 until done; they are not latched.
- y[o] updates only in FIN for that o. Other elements keep their previous values, so a restart shows old data until each element is overwritten.
- Accumulator never wraps when ACC_W meets the bound. Saturation applies only at the 16-bit output.

Optional Feature:
- Macro DEC_RELU_EN.
- Defined: in FIN, any negative saturated result is written as 0 (ReLU on the output).
- Undefined: the signed saturated value is written unchanged.
- Latency and handshake are identical in both builds.

Test Plan:
- Nominal: x all 2048, w all 205, b all 1024. Sum = 38,625,280; >>>11 = 18860; +1024 -> every y = 19884 (~9.709). done exactly 930 cycles after start.
- Positive saturation: x all 2048, w all 2047, b=0. 188324 -> every y = 32767.
- Negative saturation: w all -2048, x all 2048. -188416 -> every y = -32768 (0 with DEC_RELU_EN).
- Truncation: only x[0]=1, w[o][0]=1, b=0 -> y=0. Then x[0]=-1 -> y=-1 (0 with DEC_RELU_EN).
- Handshake: pulse start during busy -> ignored, latency unchanged. start in DONE -> done falls next edge and the decode reruns with new b (+1 on every b[o] -> every y +1).
- Reset: assert reset=0 mid-MAC (o=4) -> y, busy and done go 0 immediately without waiting for a clock edge. After release, a new start gives the full nominal result.

Source files
------------

// File: rtl/dec_92_10.sv
// Sequential dense-layer decoder: y[o] = sat16((sum_i w[o][i]*x[i]) >>> FRAC + b[o]), one shared signed MAC.
// Latency OUT_SIZE*(IN_SIZE+1) cycles from start; start ignored while busy. Optional ReLU output via `DEC_RELU_EN.
module dec_92_10 #(
    parameter int BITSIZE  = 16,
    parameter int IN_SIZE  = 92,
    parameter int OUT_SIZE = 10,
    parameter int FRAC     = 11,
    parameter int ACC_W    = 40
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [BITSIZE*IN_SIZE-1:0]          x,
    input  logic [BITSIZE*OUT_SIZE*IN_SIZE-1:0] w,
    input  logic [BITSIZE*OUT_SIZE-1:0]         b,
    output logic [BITSIZE*OUT_SIZE-1:0]         y,
    output logic                                busy,
    output logic                                done
);

    localparam int O_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam int I_W = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam logic [O_W-1:0] O_LAST = O_W'(OUT_SIZE - 1);
    localparam logic [I_W-1:0] I_LAST = I_W'(IN_SIZE - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (BITSIZE - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_FIN, S_DONE} state_t;

    state_t                     state;
    logic [O_W-1:0]             o;
    logic [I_W-1:0]             i;
    logic signed [ACC_W-1:0]    acc;
    logic signed [BITSIZE-1:0]  y_arr [OUT_SIZE];

    logic signed [BITSIZE-1:0]  x_arr [IN_SIZE];
    logic signed [BITSIZE-1:0]  w_arr [OUT_SIZE][IN_SIZE];
    logic signed [BITSIZE-1:0]  b_arr [OUT_SIZE];

    for (genvar gi = 0; gi < IN_SIZE; gi++) begin : g_x
        assign x_arr[gi] = x[gi*BITSIZE +: BITSIZE];
    end
    for (genvar go = 0; go < OUT_SIZE; go++) begin : g_o
        assign b_arr[go] = b[go*BITSIZE +: BITSIZE];
        assign y[go*BITSIZE +: BITSIZE] = y_arr[go];
        for (genvar gi = 0; gi < IN_SIZE; gi++) begin : g_w
            assign w_arr[go][gi] = w[(go*IN_SIZE+gi)*BITSIZE +: BITSIZE];
        end
    end

    logic signed [2*BITSIZE-1:0] prod;
    logic signed [ACC_W-1:0]     acc_sh;
    logic signed [ACC_W-1:0]     r;
    logic signed [BITSIZE-1:0]   sat;
    logic signed [BITSIZE-1:0]   y_new;

    // Arithmetic shift floors toward -inf; the bias is added after scaling.
    always_comb begin
        prod   = x_arr[i] * w_arr[o][i];
        acc_sh = acc >>> FRAC;
        r      = acc_sh + {{(ACC_W-BITSIZE){b_arr[o][BITSIZE-1]}}, b_arr[o]};
        if (r > SAT_MAX)
            sat = SAT_MAX[BITSIZE-1:0];
        else if (r < SAT_MIN)
            sat = SAT_MIN[BITSIZE-1:0];
        else
            sat = r[BITSIZE-1:0];
`ifdef DEC_RELU_EN
        y_new = sat[BITSIZE-1] ? '0 : sat;
`else
        y_new = sat;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            o     <= '0;
            i     <= '0;
            acc   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            for (int k = 0; k < OUT_SIZE; k++) y_arr[k] <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_MAC;
                        acc   <= '0;
                        o     <= '0;
                        i     <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                S_MAC: begin
                    acc <= acc + {{(ACC_W-2*BITSIZE){prod[2*BITSIZE-1]}}, prod};
                    if (i == I_LAST) begin
                        state <= S_FIN;
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                S_FIN: begin
                    y_arr[o] <= y_new;
                    acc      <= '0;
                    i        <= '0;
                    if (o == O_LAST) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        o     <= o + 1'b1;
                        state <= S_MAC;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_92_10.sv
// Directed, table-driven bench for dec_92_10: results, saturation, truncation, handshake, async reset.
module tb_dec_92_10;

    localparam int BITSIZE  = 16;
    localparam int IN_SIZE  = 92;
    localparam int OUT_SIZE = 10;
    localparam int LAT      = OUT_SIZE * (IN_SIZE + 1);

    logic                                clk = 1'b0;
    logic                                reset = 1'b0;
    logic                                start = 1'b0;
    logic [BITSIZE*IN_SIZE-1:0]          x = '0;
    logic [BITSIZE*OUT_SIZE*IN_SIZE-1:0] w = '0;
    logic [BITSIZE*OUT_SIZE-1:0]         b = '0;
    logic [BITSIZE*OUT_SIZE-1:0]         y;
    logic                                busy;
    logic                                done;

    dec_92_10 dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .x     (x),
        .w     (w),
        .b     (b),
        .y     (y),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // x[0]=x0, other x=xr; w[o][0]=w0+o*wstep, other w[o][i]=wr+o*wstep; b[o]=b+o*bstep; y[o]=exp0+o*estep
    typedef struct {
        int x0, xr, w0, wr, wstep, bb, bstep, exp0, estep;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic set_inputs(input vec_t v);
        for (int i = 0; i < IN_SIZE; i++)
            x[i*BITSIZE +: BITSIZE] = 16'((i == 0) ? v.x0 : v.xr);
        for (int o = 0; o < OUT_SIZE; o++) begin
            b[o*BITSIZE +: BITSIZE] = 16'(v.bb + o * v.bstep);
            for (int i = 0; i < IN_SIZE; i++)
                w[(o*IN_SIZE+i)*BITSIZE +: BITSIZE] = 16'(((i == 0) ? v.w0 : v.wr) + o * v.wstep);
        end
    endtask

    task automatic run_decode(input string tag, input bit pulse_busy);
        int lat;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk({tag, "_busy_after_start"}, int'(busy), 1);
        chk({tag, "_done_after_start"}, int'(done), 0);
        lat = 0;
        while (!done && lat < 2000) begin
            @(posedge clk);
            lat++;
            #1;
            start = (pulse_busy && lat == 100);
        end
        start = 1'b0;
        chk({tag, "_latency"}, lat, LAT);
        chk({tag, "_busy_at_done"}, int'(busy), 0);
    endtask

    task automatic check_y(input string tag, input vec_t v);
        int want, got;
        for (int o = 0; o < OUT_SIZE; o++) begin
            want = v.exp0 + o * v.estep;
`ifdef DEC_RELU_EN
            if (want < 0) want = 0;
`endif
            got = int'($signed(y[o*BITSIZE +: BITSIZE]));
            chk($sformatf("%s_y%0d", tag, o), got, want);
        end
    endtask

    initial begin
        vec_t v;
        tbl[0] = '{2048, 2048,   205,   205,  0, 1024,  0, 19884,   0};
        tbl[1] = '{2048, 2048,  2047,  2047,  0,    0,  0, 32767,   0};
        tbl[2] = '{2048, 2048, -2048, -2048,  0,    0,  0, -32768,  0};
        tbl[3] = '{   1,    0,     1,     5,  0,    0,  0,     0,   0};
        tbl[4] = '{  -1,    0,     1,     5,  0,    0,  0,    -1,   0};
        tbl[5] = '{1000, 1000,    -3,    -3,  0,    7,  0,  -128,   0};
        tbl[6] = '{2048, 2048,   100,   100, 10,    0, 50,  9200, 970};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_y", $countones(y), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        @(negedge clk) reset = 1'b1;

        for (int t = 0; t < 7; t++) begin
            set_inputs(tbl[t]);
            run_decode($sformatf("vec%0d", t), 1'b0);
            check_y($sformatf("vec%0d", t), tbl[t]);
        end

        // start pulsed mid-decode must not disturb the running decode
        set_inputs(tbl[0]);
        run_decode("busy_pulse", 1'b1);
        check_y("busy_pulse", tbl[0]);

        // restart from DONE with every bias bumped by one
        v = tbl[0];
        v.bb = 1025;
        v.exp0 = 19885;
        set_inputs(v);
        chk("restart_done_before", int'(done), 1);
        run_decode("restart", 1'b0);
        check_y("restart", v);

        // asynchronous reset while working on output 4
        set_inputs(tbl[1]);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4 * (IN_SIZE + 1) + 10) @(posedge clk);
        #3;
        chk("midrst_busy_before", int'(busy), 1);
        chk("midrst_y_before", int'(y[BITSIZE-1:0]), 32767);
        reset = 1'b0;
        #1;
        chk("midrst_y", $countones(y), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        @(negedge clk) reset = 1'b1;
        set_inputs(tbl[0]);
        run_decode("post_rst", 1'b0);
        check_y("post_rst", tbl[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
